// File: rtl/ex_div_unit_pkg.sv
// ex_div_unit_pkg: shared EX-stage defines for the stall bus and the iterative divider
package ex_div_unit_pkg;

    localparam int STALL_W    = 6;
    localparam int DIV_CYCLES = 32;

    typedef enum logic [1:0] {
        DIV_IDLE = 2'd0,
        DIV_BUSY = 2'd1,
        DIV_DONE = 2'd2
    } div_state_e;

endpackage

// File: rtl/ex_div_unit_div_step.sv
// ex_div_unit_div_step: one restoring-division iteration (shift, trial subtract, select)
module ex_div_unit_div_step #(
    parameter int W = 32
) (
    input  logic [W-1:0] rem_i,
    input  logic [W-1:0] quo_i,
    input  logic [W-1:0] dvsr_i,
    output logic [W-1:0] rem_o,
    output logic [W-1:0] quo_o
);

    logic [W:0] shifted;
    logic [W:0] diff;
    logic       keep;

    // A set shifted[W] already exceeds any W-bit divisor, so the difference is non-negative.
    always_comb begin
        shifted = {rem_i, quo_i[W-1]};
        diff    = shifted - {1'b0, dvsr_i};
        keep    = shifted[W] | ~diff[W];
        rem_o   = keep ? diff[W-1:0] : shifted[W-1:0];
        quo_o   = {quo_i[W-2:0], keep};
    end

endmodule

// File: rtl/ex_div_unit.sv
// ex_div_unit: iterative signed/unsigned divider that stalls EX until HI/LO are ready
module ex_div_unit
    import ex_div_unit_pkg::*;
#(
    parameter int DIV_WIDTH = DIV_CYCLES
) (
    input  logic                 clk,
    input  logic                 resetn,
    input  logic                 div_start,
    input  logic                 div_signed,
    input  logic [DIV_WIDTH-1:0] dividend,
    input  logic [DIV_WIDTH-1:0] divisor,
    input  logic                 div_cancel,
    output logic                 stall_for_ex,
    output logic                 div_done,
    output logic [DIV_WIDTH-1:0] quotient,
    output logic [DIV_WIDTH-1:0] remainder
);

    localparam int CW = $clog2(DIV_WIDTH);

    div_state_e           state_q, state_d;
    logic [CW-1:0]        count_q, count_d;
    logic [DIV_WIDTH-1:0] rem_q, rem_d;
    logic [DIV_WIDTH-1:0] quo_q, quo_d;
    logic [DIV_WIDTH-1:0] dvsr_q, dvsr_d;
    logic [DIV_WIDTH-1:0] quotient_q, quotient_d;
    logic [DIV_WIDTH-1:0] remainder_q, remainder_d;
    logic [DIV_WIDTH-1:0] step_rem, step_quo;
    logic                 qneg_q, qneg_d;
    logic                 rneg_q, rneg_d;
    logic                 zero_q, zero_d;
    logic                 a_neg, b_neg;

    ex_div_unit_div_step #(.W(DIV_WIDTH)) u_div_step (
        .rem_i  (rem_q),
        .quo_i  (quo_q),
        .dvsr_i (dvsr_q),
        .rem_o  (step_rem),
        .quo_o  (step_quo)
    );

    assign a_neg        = div_signed & dividend[DIV_WIDTH-1];
    assign b_neg        = div_signed & divisor[DIV_WIDTH-1];
    assign stall_for_ex = div_start && (state_q == DIV_IDLE || state_q == DIV_BUSY) && !div_cancel;
    assign div_done     = (state_q == DIV_DONE) && !div_cancel;
    assign quotient     = quotient_q;
    assign remainder    = remainder_q;

    always_comb begin
        state_d     = state_q;
        count_d     = count_q;
        rem_d       = rem_q;
        quo_d       = quo_q;
        dvsr_d      = dvsr_q;
        qneg_d      = qneg_q;
        rneg_d      = rneg_q;
        zero_d      = zero_q;
        quotient_d  = quotient_q;
        remainder_d = remainder_q;
        if (div_cancel) begin
            state_d = DIV_IDLE;
        end else begin
            case (state_q)
                DIV_IDLE: if (div_start) begin
                    state_d = DIV_BUSY;
                    quo_d   = a_neg ? -dividend : dividend;
                    dvsr_d  = b_neg ? -divisor : divisor;
                    rem_d   = '0;
                    qneg_d  = a_neg ^ b_neg;
                    rneg_d  = a_neg;
                    zero_d  = (divisor == '0);
                    count_d = CW'(DIV_WIDTH - 1);
                end
                DIV_BUSY: begin
                    rem_d   = step_rem;
                    quo_d   = step_quo;
                    count_d = count_q - 1'b1;
                    // Results are registered on the last step so they are already valid in DONE.
                    if (count_q == '0) begin
                        state_d     = DIV_DONE;
                        count_d     = '0;
                        quotient_d  = zero_q ? '1 : (qneg_q ? -step_quo : step_quo);
                        remainder_d = rneg_q ? -step_rem : step_rem;
                    end
                end
                DIV_DONE: state_d = DIV_IDLE;
                default:  state_d = DIV_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q     <= DIV_IDLE;
            count_q     <= '0;
            rem_q       <= '0;
            quo_q       <= '0;
            dvsr_q      <= '0;
            qneg_q      <= 1'b0;
            rneg_q      <= 1'b0;
            zero_q      <= 1'b0;
            quotient_q  <= '0;
            remainder_q <= '0;
        end else begin
            state_q     <= state_d;
            count_q     <= count_d;
            rem_q       <= rem_d;
            quo_q       <= quo_d;
            dvsr_q      <= dvsr_d;
            qneg_q      <= qneg_d;
            rneg_q      <= rneg_d;
            zero_q      <= zero_d;
            quotient_q  <= quotient_d;
            remainder_q <= remainder_d;
        end
    end

endmodule

// File: tb/tb_ex_div_unit.sv
// tb_ex_div_unit: directed self-checking bench for the EX-stage divider and its stall handshake
module tb_ex_div_unit;

    logic        clk = 1'b0;
    logic        resetn = 1'b0;
    logic        div_start = 1'b0;
    logic        div_signed = 1'b0;
    logic [31:0] dividend = '0;
    logic [31:0] divisor = '0;
    logic        div_cancel = 1'b0;
    logic        stall_for_ex;
    logic        div_done;
    logic [31:0] quotient;
    logic [31:0] remainder;
    int          tests = 0;
    int          fails = 0;

    ex_div_unit #(.DIV_WIDTH(32)) dut (
        .clk          (clk),
        .resetn       (resetn),
        .div_start    (div_start),
        .div_signed   (div_signed),
        .dividend     (dividend),
        .divisor      (divisor),
        .div_cancel   (div_cancel),
        .stall_for_ex (stall_for_ex),
        .div_done     (div_done),
        .quotient     (quotient),
        .remainder    (remainder)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Called on a negedge with the unit in IDLE; returns on the negedge after div_done.
    task automatic run_div(input string tag, input logic s, input logic [31:0] a, input logic [31:0] b,
                           input logic [31:0] exp_q, input logic [31:0] exp_r, input bit hold);
        int          stalls = 0;
        int          done_at = -1;
        logic        stall_at = 1'b1;
        logic [31:0] q_at = 'x;
        logic [31:0] r_at = 'x;
        div_signed = s;
        dividend   = a;
        divisor    = b;
        div_start  = 1'b1;
        for (int n = 0; n < 60 && done_at < 0; n++) begin
            #1;
            if (stall_for_ex) stalls++;
            if (div_done) begin
                done_at  = n;
                stall_at = stall_for_ex;
                q_at     = quotient;
                r_at     = remainder;
            end
            @(negedge clk);
        end
        if (!hold) div_start = 1'b0;
        chk({tag, " done_cycle"}, 32'(done_at), 32'd33);
        chk({tag, " stall_cycles"}, 32'(stalls), 32'd33);
        chk({tag, " stall_in_done"}, {31'd0, stall_at}, 32'd0);
        chk({tag, " quotient"}, q_at, exp_q);
        chk({tag, " remainder"}, r_at, exp_r);
    endtask

    initial begin
        int dones;
        #2;
        chk("rst quotient", quotient, 32'd0);
        chk("rst remainder", remainder, 32'd0);
        chk("rst div_done", {31'd0, div_done}, 32'd0);
        chk("rst stall idle", {31'd0, stall_for_ex}, 32'd0);
        div_start = 1'b1;
        #1;
        chk("rst stall follows start", {31'd0, stall_for_ex}, 32'd1);
        div_start = 1'b0;
        @(negedge clk);
        resetn = 1'b1;
        @(negedge clk);

        run_div("divu 100/7", 1'b0, 32'd100, 32'd7, 32'd14, 32'd2, 1'b0);
        run_div("div -7/2", 1'b1, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 1'b0);
        run_div("div 7/-2", 1'b1, 32'd7, 32'hFFFF_FFFE, 32'hFFFF_FFFD, 32'd1, 1'b0);
        run_div("div ovf", 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 32'd0, 1'b0);
        run_div("divu 5/0", 1'b0, 32'd5, 32'd0, 32'hFFFF_FFFF, 32'd5, 1'b0);
        run_div("div -5/0", 1'b1, 32'hFFFF_FFFB, 32'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFB, 1'b0);
        run_div("divu big", 1'b0, 32'hFFFF_FFFF, 32'h8000_0001, 32'd1, 32'h7FFF_FFFE, 1'b0);

        // Asynchronous reset mid-divide.
        div_signed = 1'b0; dividend = 32'd100; divisor = 32'd7; div_start = 1'b1;
        repeat (10) @(negedge clk);
        resetn    = 1'b0;
        div_start = 1'b0;
        #1;
        chk("mid rst quotient", quotient, 32'd0);
        chk("mid rst remainder", remainder, 32'd0);
        chk("mid rst div_done", {31'd0, div_done}, 32'd0);
        chk("mid rst stall", {31'd0, stall_for_ex}, 32'd0);
        @(negedge clk);
        resetn = 1'b1;
        dones  = 0;
        repeat (40) begin
            @(negedge clk);
            if (div_done) dones++;
        end
        chk("post rst no done", 32'(dones), 32'd0);

        // Cancel on BUSY cycle 5, then a fresh divide must take full latency.
        div_signed = 1'b0; dividend = 32'd100; divisor = 32'd7; div_start = 1'b1;
        repeat (5) @(negedge clk);
        div_cancel = 1'b1;
        #1;
        chk("cancel stall drop", {31'd0, stall_for_ex}, 32'd0);
        chk("cancel no done", {31'd0, div_done}, 32'd0);
        @(negedge clk);
        div_cancel = 1'b0;
        run_div("after cancel 9/3", 1'b0, 32'd9, 32'd3, 32'd3, 32'd0, 1'b0);

        // Back-to-back divides with div_start held across the DONE cycle.
        run_div("b2b 10/3", 1'b0, 32'd10, 32'd3, 32'd3, 32'd1, 1'b1);
        run_div("b2b 20/6", 1'b0, 32'd20, 32'd6, 32'd3, 32'd2, 1'b0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/ex_div_unit.md
# ex_div_unit

Iterative 32-bit signed/unsigned divider in the EX stage, acting as the requester side of the pipeline stall handshake. While a divide is in progress it raises `stall_for_ex` toward the stall controller, which freezes PC/IF/ID/EX. Once the divide completes it drops the request for exactly one cycle so the instruction can leave EX with the HI/LO result.

## Interface
Parameters:
- `DIV_WIDTH`, default 32: operand width; iteration count equals `DIV_WIDTH`.

Ports:
- `clk` input 1: single clock, rising edge.
- `resetn` input 1: asynchronous, active-low reset.
- `div_start` input 1: EX holds a DIV/DIVU instruction; stays high while that instruction is stalled in EX.
- `div_signed` input 1: 1 = DIV (signed), 0 = DIVU; sampled with operands.
- `dividend` input `DIV_WIDTH`: rs operand, sampled when leaving IDLE.
- `divisor` input `DIV_WIDTH`: rt operand, sampled when leaving IDLE.
- `div_cancel` input 1: synchronous abort (exception/flush); highest priority after reset.
- `stall_for_ex` output 1: stall request to the stall controller.
- `div_done` output 1: result valid this cycle; EX latches `quotient`/`remainder` into LO/HI.
- `quotient` output `DIV_WIDTH`: to LO.
- `remainder` output `DIV_WIDTH`: to HI.

## Operation
- States: IDLE, BUSY, DONE.
- IDLE: if `div_start` && !`div_cancel`, capture |dividend|, |divisor|, sign flags and the zero-divisor flag; clear the partial remainder; load `count` = `DIV_WIDTH`-1; go to BUSY.
- BUSY: one restoring step per cycle:
  - Shift {rem, quo} left by 1.
  - Trial-subtract the divisor with a `DIV_WIDTH`+1-bit subtractor.
  - If the result is non-negative, keep it and set quo[0]=1.
  - When `count`==0, go to DONE; otherwise decrement `count`.
- DONE: apply sign correction.
  - Quotient is negated if sign(dividend) XOR sign(divisor) and `div_signed`.
  - Remainder takes the sign of the dividend.
  - Assert `div_done`; always return to IDLE next cycle.
- `stall_for_ex` = `div_start` && (state==IDLE || state==BUSY) && !`div_cancel`. It is combinational, so the stall starts the same cycle the instruction enters EX and is low in DONE.
- Divide by zero: skip nothing (still full latency). `quotient` = all ones, `remainder` = dividend (unmodified, original sign).
- Signed overflow: 0x80000000 / 0xFFFFFFFF gives `quotient` = 0x80000000, `remainder` = 0. This falls out of the magnitude path; no special case.
- `div_cancel` in any state: next state IDLE, `stall_for_ex` low immediately, no `div_done`.
- `div_start` dropping in BUSY (not expected without cancel): the divide completes, and `div_done` pulses anyway.
- Back-to-back divides: the DONE cycle advances the pipeline. If the next EX instruction is also a divide, it is seen in IDLE the following cycle and starts normally.

## Timing
- Reset (`resetn` low, asynchronous):
  - State = IDLE.
  - `count` = 0.
  - `quotient` = 0, `remainder` = 0.
  - `div_done` = 0.
  - `stall_for_ex` = 0, unless `div_start` is high (combinational; the controller ignores it during its own reset).
- Latency from the first cycle `div_start` is seen in IDLE (cycle 0):
  - BUSY occupies cycles 1..`DIV_WIDTH`.
  - DONE is cycle `DIV_WIDTH`+1.
- `stall_for_ex` is high for exactly `DIV_WIDTH`+1 cycles (33 at default).
- `quotient`/`remainder` are registered outputs. They are valid in DONE and held until the next IDLE→BUSY transition.
- `div_done` is high for exactly one cycle per completed divide.

## Structure
- In the shared defines header, alongside the existing stall bus width:
  - state encodings `DIV_IDLE`/`DIV_BUSY`/`DIV_DONE` (2 bits);
  - `DIV_CYCLES`.
- One natural sub-module, `div_step`: combinational shift/trial-subtract for one iteration, instantiated once. The FSM, counter and sign logic stay in `ex_div_unit`.

## Test plan
- DIVU 100/7:
  - `stall_for_ex` high 33 consecutive cycles.
  - `div_done` on cycle 33.
  - `quotient`=14, `remainder`=2.
- DIV -7/2: `quotient`=0xFFFFFFFD, `remainder`=0xFFFFFFFF. DIV 7/-2: `quotient`=0xFFFFFFFD, `remainder`=1.
- DIV 0x80000000/0xFFFFFFFF: `quotient`=0x80000000, `remainder`=0. DIVU 5/0: `quotient`=0xFFFFFFFF, `remainder`=5, still 33 stall cycles.
- `resetn` pulled low on cycle 10 of BUSY:
  - Outputs go to 0 immediately.
  - After release with `div_start` low, no `div_done` occurs.
- `div_cancel` on cycle 5 of BUSY:
  - `stall_for_ex` drops the same cycle; state IDLE next cycle.
  - A fresh 9/3 started after that yields `quotient`=3, `remainder`=0.
- Back-to-back DIVU 10/3 then 20/6, with `div_start` held across:
  - Two separate 33-cycle stall windows separated by one DONE cycle.
  - Results (3,1) then (3,2).
